// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker for the XNOR-feedback Fibonacci LFSR generator.
// Self-synchronises on the incoming word stream, locks after a run of correct
// predictions, and counts mispredictions while locked. A flywheel predictor
// keeps lock across isolated corrupted words.
module lfsr_checker #(
   parameter int NUM_BITS   = 8,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_valid,
   input  logic [NUM_BITS-1:0]  data_in,
   input  logic                 err_clear,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_WIDTH-1:0] err_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   // Tap positions as a 16-bit mask, bit (t-1) set for 1-based tap t.
   function automatic logic [15:0] tap_mask(input int n);
      logic [15:0] m;
      case (n)
         3:       m = 16'h0006;
         4:       m = 16'h000C;
         5:       m = 16'h0014;
         6:       m = 16'h0030;
         7:       m = 16'h0060;
         8:       m = 16'h00B8;
         9:       m = 16'h0110;
         10:      m = 16'h0240;
         11:      m = 16'h0500;
         12:      m = 16'h0829;
         13:      m = 16'h100D;
         14:      m = 16'h2015;
         15:      m = 16'h6000;
         16:      m = 16'hD008;
         default: m = 16'h0000;
      endcase
      return m;
   endfunction

   localparam logic [15:0]          TAP_MASK   = tap_mask(NUM_BITS);
   localparam logic [NUM_BITS-1:0]  ALL_ONES   = {NUM_BITS{1'b1}};
   localparam logic [3:0]           LOCK_CNT_C = 4'(LOCK_COUNT);
   localparam logic [3:0]           LOSS_CNT_C = 4'(LOSS_COUNT);
   localparam logic [ERR_WIDTH-1:0] ERR_MAX    = {ERR_WIDTH{1'b1}};

   // Generator step: shift left, feedback is the XNOR chain of the taps from
   // the highest tap down.
   function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] w);
      logic [15:0] x;
      logic        f;
      logic        first;
      x     = 16'(w);
      f     = 1'b0;
      first = 1'b1;
      for (int i = 15; i >= 0; i--) begin
         if (TAP_MASK[i]) begin
            if (first) begin
               f     = x[i];
               first = 1'b0;
            end else begin
               f = f ~^ x[i];
            end
         end
      end
      return {w[NUM_BITS-2:0], f};
   endfunction

   state_t                 state_q, state_d;
   logic [NUM_BITS-1:0]    pred_q, pred_d;
   logic [3:0]             match_q, match_d;
   logic [3:0]             miss_q, miss_d;
   logic                   locked_q, locked_d;
   logic                   pulse_q, pulse_d;
   logic [ERR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   err_hit;
   logic                   is_ones;
   logic                   hit;
   logic [3:0]             match_inc;
   logic [3:0]             miss_inc;

   // Next-state logic for acquisition/lock tracking, predictor and error counter.
   always_comb begin
      state_d   = state_q;
      pred_d    = pred_q;
      match_d   = match_q;
      miss_d    = miss_q;
      pulse_d   = 1'b0;
      err_hit   = 1'b0;
      is_ones   = (data_in == ALL_ONES);
      hit       = (data_in == pred_q);
      match_inc = match_q + 4'd1;
      miss_inc  = miss_q + 4'd1;

      if (data_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (!is_ones) begin
                  pred_d  = lfsr_next(data_in);
                  match_d = 4'd0;
                  state_d = ST_ACQUIRE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACQUIRE: begin
               if (is_ones) begin
                  state_d = ST_IDLE;
               end else begin
                  pred_d = lfsr_next(data_in);
                  if (hit) begin
                     match_d = match_inc;
                     if (match_inc == LOCK_CNT_C) begin
                        state_d = ST_LOCKED;
                        miss_d  = 4'd0;
                     end else begin
                        state_d = ST_ACQUIRE;
                     end
                  end else begin
                     match_d = 4'd0;
                  end
               end
            end
            ST_LOCKED: begin
               if (hit) begin
                  pred_d = lfsr_next(data_in);
                  miss_d = 4'd0;
               end else begin
                  pulse_d = 1'b1;
                  err_hit = 1'b1;
                  if (miss_inc == LOSS_CNT_C) begin
                     state_d = ST_ACQUIRE;
                     match_d = 4'd0;
                     miss_d  = 4'd0;
                     pred_d  = lfsr_next(data_in);
                  end else begin
                     miss_d = miss_inc;
                     // Flywheel: corrupted data is never used as a seed.
                     pred_d = lfsr_next(pred_q);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // Clear wins over a simultaneous error.
      if (err_clear) begin
         cnt_d = {ERR_WIDTH{1'b0}};
      end else if (err_hit && (cnt_q != ERR_MAX)) begin
         cnt_d = cnt_q + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pred_q   <= {NUM_BITS{1'b0}};
         match_q  <= 4'd0;
         miss_q   <= 4'd0;
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
         cnt_q    <= {ERR_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         pred_q   <= pred_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
         cnt_q    <= cnt_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = pulse_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a hand-computed vector table, directed corner-case
// sequences, and a randomized stream checked against a behavioural model.
// A second instance with a 4-bit error counter shares the same stimulus.
module tb_lfsr_checker;

   localparam int NB   = 8;
   localparam int LOCK = 4;
   localparam int LOSS = 3;

   logic          clk;
   logic          rst;
   logic          data_valid;
   logic [NB-1:0] data_in;
   logic          err_clear;
   logic          locked, err_pulse;
   logic [15:0]   err_count;
   logic          locked_s, err_pulse_s;
   logic [3:0]    err_count_s;

   int n_pass  = 0;
   int n_total = 0;

   lfsr_checker #(.NUM_BITS(NB), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
      .err_clear(err_clear), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
   );

   lfsr_checker #(.NUM_BITS(NB), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
      .err_clear(err_clear), .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit taps 8,6,5,4. An XNOR chain over an even number of taps is the
   // inverted parity of those bits.
   localparam logic [7:0] TAPS  = 8'hB8;
   localparam int         NTAPS = 4;

   function automatic logic [7:0] nx(input logic [7:0] w);
      logic f;
      f = (^(w & TAPS)) ^ ((NTAPS % 2) == 0);
      return {w[6:0], f};
   endfunction

   // ---------------- reference model ----------------
   int         m_mode;   // 0 idle, 1 acquiring, 2 locked
   logic [7:0] m_pred;
   int         m_match, m_miss;
   bit         m_pulse;
   int         m_cnt16, m_cnt4;

   task automatic model_reset();
      m_mode = 0; m_pred = 8'h00; m_match = 0; m_miss = 0;
      m_pulse = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit c);
      bit err;
      err = 1'b0;
      m_pulse = 1'b0;
      if (v) begin
         if (m_mode == 0) begin
            if (d != 8'hFF) begin
               m_pred = nx(d); m_match = 0; m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (d == 8'hFF) begin
               m_mode = 0;
            end else begin
               if (d == m_pred) begin
                  m_match++;
                  if (m_match == LOCK) begin m_mode = 2; m_miss = 0; end
               end else begin
                  m_match = 0;
               end
               m_pred = nx(d);
            end
         end else begin
            if (d == m_pred) begin
               m_pred = nx(d); m_miss = 0;
            end else begin
               err = 1'b1; m_pulse = 1'b1; m_miss++;
               if (m_miss == LOSS) begin
                  m_mode = 1; m_match = 0; m_pred = nx(d);
               end else begin
                  m_pred = nx(m_pred);
               end
            end
         end
      end
      if (c) begin
         m_cnt16 = 0; m_cnt4 = 0;
      end else if (err) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt4 < 15) m_cnt4++;
      end
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Drive one cycle, then compare both instances with the model.
   task automatic apply(input bit v, input logic [7:0] d, input bit c);
      @(negedge clk);
      data_valid = v; data_in = d; err_clear = c;
      @(posedge clk);
      #1;
      model_step(v, d, c);
      check("locked",        locked,      (m_mode == 2));
      check("err_pulse",     err_pulse,   m_pulse);
      check("err_count",     err_count,   m_cnt16);
      check("locked_sat",    locked_s,    (m_mode == 2));
      check("err_pulse_sat", err_pulse_s, m_pulse);
      check("err_count_sat", err_count_s, m_cnt4);
   endtask

   logic [7:0] g;

   task automatic feed_good(input int n);
      for (int i = 0; i < n; i++) begin
         apply(1'b1, g, 1'b0);
         g = nx(g);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; data_valid = 1'b0; err_clear = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("rst_locked",    locked,    0);
      check("rst_err_pulse", err_pulse, 0);
      check("rst_err_count", err_count, 0);
   endtask

   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         c;
      bit         l;
      bit         p;
      int         cnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      rst = 1'b1; data_valid = 1'b0; data_in = 8'h00; err_clear = 1'b0;
      model_reset();

      // seed, four matches, a bit-0 error, flywheel recovery, clear, continue
      vecs[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 0};
      vecs[1] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 0};
      vecs[2] = '{1'b1, 8'h54, 1'b0, 1'b0, 1'b0, 0};
      vecs[3] = '{1'b1, 8'hA8, 1'b0, 1'b0, 1'b0, 0};
      vecs[4] = '{1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 0};
      vecs[5] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1};
      vecs[6] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0};
      vecs[8] = '{1'b1, 8'h83, 1'b0, 1'b1, 1'b0, 0};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         apply(vecs[i].v, vecs[i].d, vecs[i].c);
         check($sformatf("vec%0d_locked", i),    locked,    vecs[i].l);
         check($sformatf("vec%0d_err_pulse", i), err_pulse, vecs[i].p);
         check($sformatf("vec%0d_err_count", i), err_count, vecs[i].cnt);
      end
      g = nx(8'h83);

      // long clean run
      feed_good(1000);
      check("clean_count",  err_count, 0);
      check("clean_locked", locked,    1);

      // three consecutive errors lose lock, then relock
      for (int k = 0; k < 3; k++) begin
         apply(1'b1, g ^ 8'h01, 1'b0);
         g = nx(g);
      end
      check("loss_locked", locked,    0);
      check("loss_pulse",  err_pulse, 1);
      check("loss_count",  err_count, 3);
      feed_good(4);
      check("relock_pending", locked, 0);
      feed_good(1);
      check("relock_done",  locked,    1);
      check("relock_count", err_count, 3);

      // all-ones words in IDLE never seed
      do_reset();
      for (int k = 0; k < 5; k++) apply(1'b1, 8'hFF, 1'b0);
      check("ff_idle_locked", locked, 0);
      g = 8'h55;
      feed_good(4);
      check("ff_seed_pending", locked, 0);
      feed_good(1);
      check("ff_seed_locked", locked, 1);

      // twenty isolated errors: 16-bit counts 20, 4-bit saturates at 15
      for (int k = 0; k < 20; k++) begin
         apply(1'b1, g ^ 8'h01, 1'b0);
         g = nx(g);
         feed_good(3);
      end
      check("iso_count16", err_count,   20);
      check("iso_count4",  err_count_s, 15);
      check("iso_locked",  locked,      1);
      apply(1'b1, g ^ 8'h01, 1'b1);
      g = nx(g);
      check("clr_err_pulse", err_pulse,   1);
      check("clr_count16",   err_count,   0);
      check("clr_count4",    err_count_s, 0);

      // asynchronous reset between edges while locked with a pending pulse
      apply(1'b1, g ^ 8'h01, 1'b0);
      g = nx(g);
      #3;
      rst = 1'b1;
      #1;
      check("arst_locked",    locked,    0);
      check("arst_err_pulse", err_pulse, 0);
      check("arst_err_count", err_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      g = 8'h55;
      feed_good(5);
      check("arst_relock", locked, 1);

      // randomized stream against the model
      do_reset();
      g = 8'($urandom);
      if (g == 8'hFF) g = 8'h01;
      for (int i = 0; i < 3000; i++) begin
         bit         v, c;
         int         r;
         logic [7:0] d;
         v = (($urandom % 8) != 0);
         c = (($urandom % 64) == 0);
         r = int'($urandom % 100);
         if (r < 82)      d = g;
         else if (r < 90) d = g ^ (8'h01 << ($urandom % 8));
         else if (r < 94) d = 8'hFF;
         else             d = 8'($urandom);
         apply(v, d, c);
         if (v) g = nx(g);
         if (($urandom % 200) == 0) begin
            g = 8'($urandom);
            if (g == 8'hFF) g = 8'h00;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
